// File: rtl/vector_src_arbiter_if.sv
// Handshake bundle between the two vector producers, the arbiter and the
// register-file write port. master = producers/consumer side, slave = arbiter.
interface vector_src_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              s1_valid;
  logic              s1_last;
  logic              s1_ready;
  logic [DATA_W-1:0] s1_v0;
  logic [DATA_W-1:0] s1_v1;
  logic [DATA_W-1:0] s1_v2;
  logic [DATA_W-1:0] s1_v3;
  logic              s2_valid;
  logic              s2_last;
  logic              s2_ready;
  logic [DATA_W-1:0] s2_v0;
  logic [DATA_W-1:0] s2_v1;
  logic [DATA_W-1:0] s2_v2;
  logic [DATA_W-1:0] s2_v3;
  logic              sel;
  logic              o_valid;
  logic              o_ready;
  logic              o_src;
  logic [DATA_W-1:0] o_v0;
  logic [DATA_W-1:0] o_v1;
  logic [DATA_W-1:0] o_v2;
  logic [DATA_W-1:0] o_v3;

  modport master (
    output s1_valid, s1_last, s1_v0, s1_v1, s1_v2, s1_v3,
    output s2_valid, s2_last, s2_v0, s2_v1, s2_v2, s2_v3,
    output o_ready,
    input  s1_ready, s2_ready, sel, o_valid, o_src,
    input  o_v0, o_v1, o_v2, o_v3
  );

  modport slave (
    input  s1_valid, s1_last, s1_v0, s1_v1, s1_v2, s1_v3,
    input  s2_valid, s2_last, s2_v0, s2_v1, s2_v2, s2_v3,
    input  o_ready,
    output s1_ready, s2_ready, sel, o_valid, o_src,
    output o_v0, o_v1, o_v2, o_v3
  );
endinterface

// File: rtl/vector_src_arbiter.sv
// Burst arbiter for the shared 4-lane vector mux with a registered output stage.
// Define VARB_ROUND_ROBIN_EN for round-robin tie breaking (default: src1 priority).
module vector_src_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  vector_src_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } state_t;

  localparam logic [7:0] CNT_END = 8'(MAX_BURST - 1);

  state_t            state;
  state_t            state_nx;
  logic              sel_q;
  logic              sel_nx;
  logic [7:0]        cnt;
  logic [7:0]        cnt_nx;
  logic              last_grant;
  logic              lg_nx;
  logic              o_valid_q;
  logic              o_valid_nx;
  logic              o_src_q;
  logic [DATA_W-1:0] o_v0_q;
  logic [DATA_W-1:0] o_v1_q;
  logic [DATA_W-1:0] o_v2_q;
  logic [DATA_W-1:0] o_v3_q;
  logic              take;
  logic              xfer;
  logic              src;
  logic              last;
  logic              tie2;
  logic              pick2;

  assign take = !o_valid_q || bus.o_ready;
  assign bus.s1_ready = (state == GRANT1) && take;
  assign bus.s2_ready = (state == GRANT2) && take;
  assign src  = (state == GRANT2);
  assign last = src ? bus.s2_last : bus.s1_last;
  assign xfer = (bus.s1_valid && bus.s1_ready)
             || (bus.s2_valid && bus.s2_ready);

  // last_grant = 1 means src2 was served last
`ifdef VARB_ROUND_ROBIN_EN
  assign tie2 = !last_grant;
`else
  assign tie2 = 1'b0;
`endif
  assign pick2 = bus.s2_valid && (!bus.s1_valid || tie2);

  always_comb begin
    state_nx   = state;
    sel_nx     = sel_q;
    cnt_nx     = cnt;
    lg_nx      = last_grant;
    o_valid_nx = o_valid_q && !bus.o_ready;
    if (xfer) o_valid_nx = 1'b1;
    unique case (1'b1)
      (state == IDLE): begin
        if (bus.s1_valid || bus.s2_valid) begin
          state_nx = pick2 ? GRANT2 : GRANT1;
          sel_nx   = pick2;
        end
      end
      default: begin
        if (xfer) begin
          if (last || cnt == CNT_END) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            lg_nx    = src;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel_q      <= 1'b0;
      cnt        <= '0;
      last_grant <= 1'b1;
      o_valid_q  <= 1'b0;
      o_src_q    <= 1'b0;
      o_v0_q     <= '0;
      o_v1_q     <= '0;
      o_v2_q     <= '0;
      o_v3_q     <= '0;
    end else begin
      state      <= state_nx;
      sel_q      <= sel_nx;
      cnt        <= cnt_nx;
      last_grant <= lg_nx;
      o_valid_q  <= o_valid_nx;
      if (xfer) begin
        o_src_q <= src;
        o_v0_q  <= sel_q ? bus.s2_v0 : bus.s1_v0;
        o_v1_q  <= sel_q ? bus.s2_v1 : bus.s1_v1;
        o_v2_q  <= sel_q ? bus.s2_v2 : bus.s1_v2;
        o_v3_q  <= sel_q ? bus.s2_v3 : bus.s1_v3;
      end
    end
  end

  assign bus.sel     = sel_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_src   = o_src_q;
  assign bus.o_v0    = o_v0_q;
  assign bus.o_v1    = o_v1_q;
  assign bus.o_v2    = o_v2_q;
  assign bus.o_v3    = o_v3_q;
endmodule

// File: tb/tb_vector_src_arbiter.sv
// Directed bench for vector_src_arbiter: queue-driven producers, a burst-level
// reference model, in-order delivery scoreboard and hand-computed literals.
module tb_vector_src_arbiter;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_src_arbiter_if #(.DATA_W(32)) vif ();

  vector_src_arbiter #(
    .DATA_W(32),
    .MAX_BURST(MAXB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(vif)
  );

  typedef struct packed {
    logic            last;
    logic [3:0][31:0] v;
  } beat_t;

  beat_t q1[$];
  beat_t q2[$];
  beat_t e1[$];
  beat_t e2[$];
  int    log_src[$];
  int    nvec = 0;
  int    nerr = 0;

  int              m_owner = 0;
  int              m_cnt = 0;
  int              m_lastg = 2;
  logic            m_sel = 1'b0;
  logic            m_valid = 1'b0;
  logic            m_src = 1'b0;
  logic [3:0][31:0] m_data = '0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic put(input int s, input beat_t b, input logic on);
    if (s == 1) begin
      vif.s1_valid = on;
      vif.s1_last  = b.last;
      vif.s1_v0 = b.v[0];
      vif.s1_v1 = b.v[1];
      vif.s1_v2 = b.v[2];
      vif.s1_v3 = b.v[3];
    end else begin
      vif.s2_valid = on;
      vif.s2_last  = b.last;
      vif.s2_v0 = b.v[0];
      vif.s2_v1 = b.v[1];
      vif.s2_v2 = b.v[2];
      vif.s2_v3 = b.v[3];
    end
  endtask

  function automatic beat_t cur(input int s);
    beat_t b;
    if (s == 1) begin
      b.last = vif.s1_last;
      b.v = {vif.s1_v3, vif.s1_v2, vif.s1_v1, vif.s1_v0};
    end else begin
      b.last = vif.s2_last;
      b.v = {vif.s2_v3, vif.s2_v2, vif.s2_v1, vif.s2_v0};
    end
    return b;
  endfunction

  task automatic push(input int s, input logic l, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c,
                      input logic [31:0] d);
    beat_t x;
    x.last = l;
    x.v = {d, c, b, a};
    if (s == 1) begin
      q1.push_back(x);
      e1.push_back(x);
    end else begin
      q2.push_back(x);
      e2.push_back(x);
    end
  endtask

  // producers: present queue head, pop after an observed handshake
  initial begin : prod1
    bit t;
    forever begin
      @(negedge clk);
      t = vif.s1_valid && vif.s1_ready;
      @(posedge clk);
      #1;
      if (t && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) put(1, q1[0], 1'b1);
      else put(1, '0, 1'b0);
    end
  end

  initial begin : prod2
    bit t;
    forever begin
      @(negedge clk);
      t = vif.s2_valid && vif.s2_ready;
      @(posedge clk);
      #1;
      if (t && q2.size() > 0) void'(q2.pop_front());
      if (q2.size() > 0) put(2, q2[0], 1'b1);
      else put(2, '0, 1'b0);
    end
  end

  // burst-level reference: who owns the mux, how many beats, what is held
  initial begin : model
    logic  v1, v2, fire;
    beat_t b;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = 0;
        m_cnt   = 0;
        m_lastg = 2;
        m_sel   = 1'b0;
        m_valid = 1'b0;
        m_src   = 1'b0;
        m_data  = '0;
      end else begin
        v1 = vif.s1_valid;
        v2 = vif.s2_valid;
        if (m_owner == 0) begin
          if (vif.o_ready) m_valid = 1'b0;
          if (v1 || v2) begin
            m_owner = v1 ? 1 : 2;
`ifdef VARB_ROUND_ROBIN_EN
            if (v1 && v2 && m_lastg == 1) m_owner = 2;
`endif
            m_sel = (m_owner == 2);
          end
        end else begin
          fire = (m_owner == 1 ? v1 : v2) && (!m_valid || vif.o_ready);
          if (fire) begin
            b = cur(m_owner);
            m_data  = b.v;
            m_src   = (m_owner == 2);
            m_valid = 1'b1;
            m_cnt++;
            if (b.last || m_cnt == MAXB) begin
              m_lastg = m_owner;
              m_owner = 0;
              m_cnt   = 0;
            end
          end else if (vif.o_ready) begin
            m_valid = 1'b0;
          end
        end
      end
    end
  end

  initial begin : compare
    logic  r1, r2;
    beat_t b;
    forever begin
      @(negedge clk);
      r1 = rst_n && m_owner == 1 && (!m_valid || vif.o_ready);
      r2 = rst_n && m_owner == 2 && (!m_valid || vif.o_ready);
      chk("s1_ready", 32'(vif.s1_ready), 32'(r1));
      chk("s2_ready", 32'(vif.s2_ready), 32'(r2));
      chk("sel", 32'(vif.sel), 32'(m_sel));
      chk("o_valid", 32'(vif.o_valid), 32'(m_valid));
      if (m_valid) begin
        chk("o_src", 32'(vif.o_src), 32'(m_src));
        chk("o_v0", vif.o_v0, m_data[0]);
        chk("o_v1", vif.o_v1, m_data[1]);
        chk("o_v2", vif.o_v2, m_data[2]);
        chk("o_v3", vif.o_v3, m_data[3]);
      end
      if (rst_n && vif.o_valid && vif.o_ready) begin
        log_src.push_back(int'(vif.o_src));
        if (vif.o_src ? e2.size() == 0 : e1.size() == 0) begin
          chk("extra_beat", 32'(vif.o_src), 32'hFFFF_FFFF);
        end else begin
          if (vif.o_src) b = e2.pop_front();
          else b = e1.pop_front();
          chk("order_v0", vif.o_v0, b.v[0]);
          chk("order_v1", vif.o_v1, b.v[1]);
          chk("order_v2", vif.o_v2, b.v[2]);
          chk("order_v3", vif.o_v3, b.v[3]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_log(input int n, input int lim);
    int k = 0;
    while (log_src.size() < n && k < lim) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("wait_log", 32'(log_src.size() >= n), 32'd1);
  endtask

  task automatic cmp_log(input string n, input int exp[$]);
    chk({n, "_len"}, 32'(log_src.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < log_src.size())
        chk({n, "_src"}, 32'(log_src[i]), 32'(exp[i]));
  endtask

  task automatic clear_all();
    q1.delete();
    q2.delete();
    e1.delete();
    e2.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int exp3[$];
    int exp4[$];
    int k;
`ifdef VARB_ROUND_ROBIN_EN
    exp3 = '{0, 0, 1, 1, 0, 0, 1, 1};
    exp4 = '{0, 0, 0, 0, 1, 0, 0};
`else
    exp3 = '{0, 0, 0, 0, 1, 1, 1, 1};
    exp4 = '{0, 0, 0, 0, 0, 0};
`endif
    vif.o_ready = 1'b1;
    put(1, '0, 1'b0);
    put(2, '0, 1'b0);

    // reset held with a pending single beat
    push(1, 1'b1, 32'h41BA6666, 32'h3F99999A, 32'h40666666, 32'h40B9999A);
    repeat (3) @(negedge clk);
    chk("rst_o_valid", 32'(vif.o_valid), 32'd0);
    chk("rst_sel", 32'(vif.sel), 32'd0);
    chk("rst_s1_ready", 32'(vif.s1_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(vif.s1_ready), 32'd0);
    @(negedge clk);
    chk("grant_ready", 32'(vif.s1_ready), 32'd1);
    @(negedge clk);
    chk("single_valid", 32'(vif.o_valid), 32'd1);
    chk("single_v0", vif.o_v0, 32'h41BA6666);
    chk("single_v1", vif.o_v1, 32'h3F99999A);
    chk("single_v2", vif.o_v2, 32'h40666666);
    chk("single_v3", vif.o_v3, 32'h40B9999A);
    chk("single_src", 32'(vif.o_src), 32'd0);
    @(negedge clk);
    chk("single_drain", 32'(vif.o_valid), 32'd0);

    // backpressure on a 3-beat src2 burst
    tick();
    log_src.delete();
    vif.o_ready = 1'b0;
    push(2, 1'b0, 32'h40DCCCCD, 32'h40E00000, 32'h40E66666, 32'h40ECCCCD);
    push(2, 1'b0, 32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000);
    push(2, 1'b1, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    k = 0;
    while (!vif.o_valid && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("bp_first_v0", vif.o_v0, 32'h40DCCCCD);
    chk("bp_first_src", 32'(vif.o_src), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_s2_ready", 32'(vif.s2_ready), 32'd0);
    end
    chk("bp_hold_v0", vif.o_v0, 32'h40DCCCCD);
    tick();
    vif.o_ready = 1'b1;
    wait_log(3, 12);
    cmp_log("bp", '{1, 1, 1});

    // ties with bursts of two on both sources
    tick();
    log_src.delete();
    for (int i = 0; i < 2; i++) begin
      push(1, 1'b0, 32'h10 + i, 32'h11, 32'h12, 32'h13);
      push(1, 1'b1, 32'h20 + i, 32'h21, 32'h22, 32'h23);
      push(2, 1'b0, 32'h30 + i, 32'h31, 32'h32, 32'h33);
      push(2, 1'b1, 32'h40 + i, 32'h41, 32'h42, 32'h43);
    end
    wait_log(8, 30);
    cmp_log("tie", exp3);

    // forced release after MAXB beats with src2 waiting
    tick();
    log_src.delete();
    for (int i = 0; i < 6; i++)
      push(1, 1'b0, 32'h500 + i, 32'h501, 32'h502, 32'h503);
    tick();
    push(2, 1'b1, 32'h600, 32'h601, 32'h602, 32'h603);
    repeat (16) @(negedge clk);
    cmp_log("maxb", exp4);

    // clean up the held grant, then reset in the middle of a burst
    tick();
    rst_n = 1'b0;
    clear_all();
    repeat (2) tick();
    rst_n = 1'b1;
    log_src.delete();
    push(1, 1'b0, 32'h700, 32'h701, 32'h702, 32'h703);
    push(1, 1'b0, 32'h710, 32'h711, 32'h712, 32'h713);
    push(1, 1'b1, 32'h720, 32'h721, 32'h722, 32'h723);
    wait_log(1, 10);
    chk("mid_valid_pre", 32'(vif.o_valid), 32'd1);
    rst_n = 1'b0;
    clear_all();
    #1;
    chk("mid_o_valid", 32'(vif.o_valid), 32'd0);
    chk("mid_sel", 32'(vif.sel), 32'd0);
    chk("mid_s1_ready", 32'(vif.s1_ready), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    log_src.delete();
    push(2, 1'b1, 32'h800, 32'h801, 32'h802, 32'h803);
    wait_log(1, 10);
    repeat (3) @(negedge clk);
    cmp_log("rearb", '{1});
    chk("e1_empty", 32'(e1.size()), 32'd0);
    chk("e2_empty", 32'(e2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
